rxe_pktctl: RTL and testbench
=============================

// Module: rxe_pktctl
// PURPOSE
//  Receive-packet controller for the MII nibble path. It sequences the preamble stripper:
//  drives its enable and cancel inputs, and watches raw and stripped valids.
//  Enforces preamble timeout, min/max frame length and inter-frame gap; aborts frames on
//  rx error or downstream overflow. Reports per-frame done/abort and keeps saturating stats.
// PARAMETERS
//  MIN_NIB  128   min good frame length, nibbles after SFD (64 bytes)
//  MAX_NIB  3036  max frame length, nibbles (1518 bytes); longer -> abort
//  MAX_PRE  24    max nibbles of raw valid before first stripped nibble
//  IFG_NIB  24    idle nibbles required between frames (12 bytes)
//  LW       12    width of o_len (bytes)
//  CW       16    width of each statistics counter
// PORTS
//  i_clk       in   1   system clock
//  i_reset_n   in   1   asynchronous, active-low reset
//  i_ce        in   1   MII nibble strobe; all state advances only when high
//  i_en        in   1   software receive enable
//  i_ovfl      in   1   downstream FIFO overflow; aborts the current frame
//  i_clrstats  in   1   clear all statistics counters
//  i_v         in   1   raw MII rx valid
//  i_err       in   1   raw MII rx error
//  i_pv        in   1   stripped-stream valid from the preamble stripper
//  o_en        out  1   stripper enable
//  o_cancel    out  1   stripper cancel
//  o_busy      out  1   frame in progress (PRE/DATA/DRAIN)
//  o_done      out  1   one-i_ce pulse: good frame ended; o_len valid
//  o_abort     out  1   one-i_ce pulse: frame dropped (any reason)
//  o_len       out  LW  byte length of the last good frame
//  o_good/o_runt/o_long/o_bad  out  CW  frame counters
// BEHAVIOUR
//  - Reset: state=DISABLED; o_en, o_cancel, o_busy, o_done, o_abort = 0; o_len = 0; counters = 0.
//  - All outputs registered. Response appears on the clock edge of the i_ce cycle that
//    causes it. o_done/o_abort are high for exactly one i_ce period, then clear.
//  - States (transitions evaluated only when i_ce=1):
//    DISABLED: o_en=0. If i_en, go to GAP (line must first be idle IFG_NIB nibbles).
//    GAP: o_en=0. gapcnt counts nibbles with i_v=0; reset to 0 on i_v=1.
//         At IFG_NIB: go to IDLE if i_en, else DISABLED.
//    IDLE: o_en=1. i_v=1 -> PRE, with precnt=1. !i_en -> DISABLED.
//    PRE: precnt++. i_pv=1 -> DATA, nibcnt=1.
//         i_v=0 with no i_pv (no SFD) -> bad++, abort, GAP.
//         precnt==MAX_PRE -> bad++, abort, DRAIN.
//    DATA: nibcnt++ on each i_pv=1 (saturates at MAX_NIB+1).
//         Abort conditions: i_err, i_ovfl, or nibcnt>MAX_NIB.
//           i_err/i_ovfl -> bad++; length overrun -> long++. Then abort, DRAIN.
//         End of frame: i_v=0 and i_pv=0.
//           nibcnt odd -> bad++, abort.
//           nibcnt<MIN_NIB -> runt++, abort.
//           otherwise good++, o_len=nibcnt>>1, o_done.
//           In all three cases, go to GAP.
//    DRAIN: o_cancel=1 and o_en=0 until i_v=0, then o_cancel=0 -> GAP.
//  - Priority within a single i_ce: abort conditions > end-of-frame > counting.
//    Exactly one counter increments per frame.
//  - i_en deasserted mid-frame: the frame completes normally; the FSM goes to DISABLED after GAP.
//  - o_busy = state in {PRE, DATA, DRAIN}.
//  - Counters saturate at all ones. i_clrstats wins over a same-cycle increment; the result is 0.
//    i_clrstats acts regardless of i_ce.
//  - Async reset mid-frame: immediate return to reset values. The next frame is only accepted
//    after a full GAP, so a partial frame cannot be captured.
// STRUCTURE
//  - Shared package rxe_pkg: FSM state encoding (DISABLED, GAP, IDLE, PRE, DATA, DRAIN);
//    default MIN_NIB/MAX_NIB/MAX_PRE/IFG_NIB.
//  - Sub-module rxe_satcount (CW-bit saturating counter with inc/clr; clr has priority),
//    instantiated 4x.
//  - FSM, gap/pre/nibble counters and o_len stay in this module.
// TESTING
//  1. i_en=1, 24 idle nibbles, 16-nibble preamble/SFD, then 128 data nibbles with i_pv
//     -> o_done once, o_len=64, good=1.
//  2. Frame with 3040 data nibbles -> abort at the 3037th nibble; o_cancel held until i_v=0;
//     long=1; o_done never asserted.
//  3. i_err pulse at data nibble 50 -> bad=1, abort pulse, DRAIN.
//     The next frame, started after 24 idle nibbles, is good.
//  4. 60-nibble frame -> runt=1. 129-nibble frame -> bad=1.
//     A new frame arriving after only 10 idle nibbles is ignored (o_en=0, no counter change).
//  5. i_v held 30 nibbles without i_pv -> abort at precnt=24, bad=1.
//     Async reset asserted mid-DATA -> all outputs 0; FSM back to DISABLED.
//  6. counters at 16'hFFFF plus one more good frame -> remain 16'hFFFF.
//     i_clrstats on the same cycle as an increment -> counter reads 0.

Source files
------------

// File: rtl/rxe_pkg.sv
// rxe_pkg: shared state encoding and default frame limits for the MII receive controller
package rxe_pkg;
   typedef enum logic [2:0] {S_DISABLED, S_GAP, S_IDLE, S_PRE, S_DATA, S_DRAIN} rx_state_t;
   localparam int MIN_NIB_DEF = 128;
   localparam int MAX_NIB_DEF = 3036;
   localparam int MAX_PRE_DEF = 24;
   localparam int IFG_NIB_DEF = 24;
endpackage

// File: rtl/rxe_satcount.sv
// rxe_satcount: saturating statistics counter, clear beats increment
module rxe_satcount #(
   parameter int CW = 16
) (
   input  logic          i_clk,
   input  logic          i_reset_n,
   input  logic          i_inc,
   input  logic          i_clr,
   output logic [CW-1:0] o_q
);
   always_ff @(posedge i_clk or negedge i_reset_n)
      if (!i_reset_n) o_q <= '0;
      else if (i_clr) o_q <= '0;
      else if (i_inc && !(&o_q)) o_q <= o_q + 1'b1;
endmodule

// File: rtl/rxe_pktctl.sv
// rxe_pktctl: MII receive-packet controller sequencing the preamble stripper and keeping frame stats
module rxe_pktctl
   import rxe_pkg::*;
#(
   parameter int MIN_NIB = MIN_NIB_DEF,
   parameter int MAX_NIB = MAX_NIB_DEF,
   parameter int MAX_PRE = MAX_PRE_DEF,
   parameter int IFG_NIB = IFG_NIB_DEF,
   parameter int LW      = 12,
   parameter int CW      = 16
) (
   input  logic          i_clk,
   input  logic          i_reset_n,
   input  logic          i_ce,
   input  logic          i_en,
   input  logic          i_ovfl,
   input  logic          i_clrstats,
   input  logic          i_v,
   input  logic          i_err,
   input  logic          i_pv,
   output logic          o_en,
   output logic          o_cancel,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_abort,
   output logic [LW-1:0] o_len,
   output logic [CW-1:0] o_good,
   output logic [CW-1:0] o_runt,
   output logic [CW-1:0] o_long,
   output logic [CW-1:0] o_bad
);
   localparam int GW = $clog2(IFG_NIB + 1);
   localparam int PW = $clog2(MAX_PRE + 1);
   localparam int NW = $clog2(MAX_NIB + 2);

   rx_state_t      st;
   logic [GW-1:0]  gapcnt;
   logic [PW-1:0]  precnt;
   logic [NW-1:0]  nibcnt, nib_nx;
   logic           ovr, fail, eof, in_pre, in_dat, end_ok;
   logic           inc_good, inc_runt, inc_long, inc_bad;

   // nib_nx includes the nibble on the wire, so overrun fires on the first nibble past MAX_NIB
   always_comb begin
      nib_nx   = (i_pv && nibcnt <= NW'(MAX_NIB)) ? nibcnt + 1'b1 : nibcnt;
      ovr      = nib_nx > NW'(MAX_NIB);
      fail     = i_err || i_ovfl;
      eof      = !i_v && !i_pv;
      in_pre   = i_ce && st == S_PRE && !i_pv;
      in_dat   = i_ce && st == S_DATA;
      end_ok   = in_dat && !fail && !ovr && eof;
      inc_bad  = (in_pre && (!i_v || precnt == PW'(MAX_PRE))) || (in_dat && fail) || (end_ok && nibcnt[0]);
      inc_long = in_dat && !fail && ovr;
      inc_runt = end_ok && !nibcnt[0] && nibcnt < NW'(MIN_NIB);
      inc_good = end_ok && !nibcnt[0] && nibcnt >= NW'(MIN_NIB);
   end

   always_ff @(posedge i_clk or negedge i_reset_n)
      if (!i_reset_n) begin
         st       <= S_DISABLED;
         gapcnt   <= '0;
         precnt   <= '0;
         nibcnt   <= '0;
         o_en     <= 1'b0;
         o_cancel <= 1'b0;
         o_busy   <= 1'b0;
         o_done   <= 1'b0;
         o_abort  <= 1'b0;
         o_len    <= '0;
      end else if (i_ce) begin
         o_done  <= 1'b0;
         o_abort <= 1'b0;
         case (st)
            S_DISABLED:
               if (i_en) begin
                  st     <= S_GAP;
                  gapcnt <= GW'(!i_v);
               end
            S_GAP:
               if (i_v) gapcnt <= '0;
               else if (gapcnt == GW'(IFG_NIB - 1)) begin
                  st   <= i_en ? S_IDLE : S_DISABLED;
                  o_en <= i_en;
               end else gapcnt <= gapcnt + 1'b1;
            S_IDLE:
               if (!i_en) begin
                  st   <= S_DISABLED;
                  o_en <= 1'b0;
               end else if (i_v) begin
                  st     <= S_PRE;
                  precnt <= PW'(1);
                  o_busy <= 1'b1;
               end
            S_PRE:
               if (i_pv) begin
                  st     <= S_DATA;
                  nibcnt <= NW'(1);
               end else if (!i_v) begin
                  st      <= S_GAP;
                  gapcnt  <= GW'(1);
                  o_en    <= 1'b0;
                  o_busy  <= 1'b0;
                  o_abort <= 1'b1;
               end else if (precnt == PW'(MAX_PRE)) begin
                  st       <= S_DRAIN;
                  o_en     <= 1'b0;
                  o_cancel <= 1'b1;
                  o_abort  <= 1'b1;
               end else precnt <= precnt + 1'b1;
            S_DATA:
               if (fail || ovr) begin
                  st       <= S_DRAIN;
                  o_en     <= 1'b0;
                  o_cancel <= 1'b1;
                  o_abort  <= 1'b1;
               end else if (eof) begin
                  st      <= S_GAP;
                  gapcnt  <= GW'(1);
                  o_en    <= 1'b0;
                  o_busy  <= 1'b0;
                  o_done  <= inc_good;
                  o_abort <= !inc_good;
                  o_len   <= inc_good ? LW'(nibcnt >> 1) : o_len;
               end else nibcnt <= nib_nx;
            S_DRAIN:
               if (!i_v) begin
                  st       <= S_GAP;
                  gapcnt   <= GW'(1);
                  o_cancel <= 1'b0;
                  o_busy   <= 1'b0;
               end
            default: st <= S_DISABLED;
         endcase
      end

   rxe_satcount #(.CW(CW)) u_good (.i_clk(i_clk), .i_reset_n(i_reset_n), .i_inc(inc_good), .i_clr(i_clrstats), .o_q(o_good));
   rxe_satcount #(.CW(CW)) u_runt (.i_clk(i_clk), .i_reset_n(i_reset_n), .i_inc(inc_runt), .i_clr(i_clrstats), .o_q(o_runt));
   rxe_satcount #(.CW(CW)) u_long (.i_clk(i_clk), .i_reset_n(i_reset_n), .i_inc(inc_long), .i_clr(i_clrstats), .o_q(o_long));
   rxe_satcount #(.CW(CW)) u_bad  (.i_clk(i_clk), .i_reset_n(i_reset_n), .i_inc(inc_bad),  .i_clr(i_clrstats), .o_q(o_bad));
endmodule

// File: tb/tb_rxe_pktctl.sv
// tb_rxe_pktctl: frame-level randomized bench with an outcome scoreboard for rxe_pktctl
module tb_rxe_pktctl;
   localparam int CW = 5, LW = 12, IFG = 24, MAXPRE = 24, MAXNIB = 3036, MINNIB = 128;
   localparam int SAT = (1 << CW) - 1;

   logic i_clk, i_reset_n, i_ce, i_en, i_ovfl, i_clrstats, i_v, i_err, i_pv;
   logic o_en, o_cancel, o_busy, o_done, o_abort;
   logic [LW-1:0] o_len;
   logic [CW-1:0] o_good, o_runt, o_long, o_bad;

   rxe_pktctl #(.LW(LW), .CW(CW)) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_ce(i_ce), .i_en(i_en), .i_ovfl(i_ovfl),
      .i_clrstats(i_clrstats), .i_v(i_v), .i_err(i_err), .i_pv(i_pv),
      .o_en(o_en), .o_cancel(o_cancel), .o_busy(o_busy), .o_done(o_done), .o_abort(o_abort),
      .o_len(o_len), .o_good(o_good), .o_runt(o_runt), .o_long(o_long), .o_bad(o_bad)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {bit done; int len; int good, runt, lng, bad;} ev_t;
   ev_t exp_q[$];
   int  n_cmp = 0, n_bad = 0;
   int  cnt[4];
   int  idle_run, last_len;
   logic mon_ce;

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, a, e, $time);
      end
   endtask

   initial forever begin
      @(posedge i_clk);
      mon_ce = i_ce && i_reset_n;
      #1;
      if (mon_ce && (o_done || o_abort)) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event: got done=%0b abort=%0b, expected none (t=%0t)", o_done, o_abort, $time);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            chk("ev_done", o_done, e.done);
            chk("ev_abort", o_abort, !e.done);
            chk("ev_len", o_len, e.len);
            chk("ev_good", o_good, e.good);
            chk("ev_runt", o_runt, e.runt);
            chk("ev_long", o_long, e.lng);
            chk("ev_bad", o_bad, e.bad);
         end
      end
   end

   initial begin
      #950000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   task automatic nib(input logic v, input logic pv, input logic err, input logic ovfl);
      @(negedge i_clk);
      while ($urandom_range(0, 3) == 0) begin
         i_ce = 1'b0;
         {i_v, i_pv, i_err, i_ovfl} = 4'($urandom);
         @(negedge i_clk);
      end
      i_ce = 1'b1; i_v = v; i_pv = pv; i_err = err; i_ovfl = ovfl;
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         nib(0, 0, 0, 0);
         idle_run = i_en ? idle_run + 1 : 0;
         chk("gap_en", o_en, i_en && idle_run >= IFG);
         chk("gap_busy", o_busy, 0);
      end
   endtask

   // kind: 1 good, 2 runt, 3 long, 4 bad
   task automatic frame(input int gap, input int p, input int d, input int errpos, input int ovflpos,
                        input bit clr_eof, input bit en_drop);
      int ev_r = 0, kind = 0, fp = 0;
      bit acc, drain = 0;
      idle(gap);
      acc = idle_run >= IFG;
      idle_run = 0;
      if (acc) begin
         if (errpos >= 1 && errpos <= d) fp = errpos;
         if (ovflpos >= 1 && ovflpos <= d && (fp == 0 || ovflpos < fp)) fp = ovflpos;
         if (p > MAXPRE) begin ev_r = MAXPRE + 1; kind = 4; drain = 1; end
         else if (d == 0) begin ev_r = p + 1; kind = 4; end
         else if (fp != 0 && fp <= MAXNIB + 1) begin ev_r = p + fp; kind = 4; drain = 1; end
         else if (d > MAXNIB) begin ev_r = p + MAXNIB + 1; kind = 3; drain = 1; end
         else begin ev_r = p + d + 1; kind = (d % 2) ? 4 : (d < MINNIB) ? 2 : 1; end
      end
      for (int r = 1; r <= p + d + 1; r++) begin
         bit last = (r == p + d + 1);
         bit exp_c;
         if (en_drop && r == p + d / 2 + 1) i_en = 1'b0;
         if (last) i_en = 1'b1;
         if (last && clr_eof) begin
            i_clrstats = 1'b1;
            cnt = '{0, 0, 0, 0};
         end
         if (r == ev_r) begin
            ev_t e;
            if (!(last && clr_eof)) cnt[kind-1] = cnt[kind-1] < SAT ? cnt[kind-1] + 1 : SAT;
            if (kind == 1) last_len = d / 2;
            e.done = kind == 1; e.len = last_len;
            e.good = cnt[0]; e.runt = cnt[1]; e.lng = cnt[2]; e.bad = cnt[3];
            exp_q.push_back(e);
         end
         nib(!last, !last && r > p, !last && r > p && r - p == errpos, !last && r > p && r - p == ovflpos);
         i_clrstats = 1'b0;
         if (acc) begin
            exp_c = drain && !last && r >= ev_r;
            chk("frm_cancel", o_cancel, exp_c);
            chk("frm_en", o_en, !last && !exp_c);
            chk("frm_busy", o_busy, !last);
         end else begin
            chk("rej_en", o_en, 0);
            chk("rej_busy", o_busy, 0);
            chk("rej_cancel", o_cancel, 0);
         end
      end
      idle_run = 1;
   endtask

   initial begin
      i_reset_n = 1'b1;
      {i_ce, i_en, i_ovfl, i_clrstats, i_v, i_err, i_pv} = '0;
      cnt = '{0, 0, 0, 0};
      idle_run = 0;
      last_len = 0;
      #1 i_reset_n = 1'b0;
      #20;
      chk("rst_en", o_en, 0);
      chk("rst_cancel", o_cancel, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_abort", o_abort, 0);
      chk("rst_len", o_len, 0);
      chk("rst_cnt", {o_good, o_runt, o_long, o_bad}, 0);
      @(negedge i_clk);
      i_reset_n = 1'b1;
      i_en = 1'b1;
      // directed cases
      frame(30, 16, 128, 0, 0, 0, 0);
      frame(24, 16, 3040, 0, 0, 0, 0);
      frame(24, 16, 200, 50, 0, 0, 0);
      frame(23, 16, 130, 0, 0, 0, 0);
      frame(24, 16, 60, 0, 0, 0, 0);
      frame(24, 16, 129, 0, 0, 0, 0);
      frame(10, 16, 128, 0, 0, 0, 0);
      frame(22, 16, 128, 0, 0, 0, 0);
      frame(30, 24, 128, 0, 0, 0, 0);
      frame(24, 30, 40, 0, 0, 0, 0);
      frame(24, 16, 0, 0, 0, 0, 0);
      frame(24, 16, 126, 0, 0, 0, 0);
      frame(24, 16, 150, 0, 70, 0, 0);
      frame(24, 16, 3036, 0, 0, 0, 0);
      frame(24, 16, 180, 0, 0, 0, 1);
      frame(24, 16, 132, 0, 0, 1, 0);
      idle(30);
      i_en = 1'b0;
      idle(5);
      i_en = 1'b1;
      frame(23, 16, 140, 0, 0, 0, 0);
      // saturate the good counter
      for (int i = 0; i < 35; i++) frame(24, 16, 128 + 2 * $urandom_range(0, 6), 0, 0, 0, 0);
      // randomized traffic
      for (int i = 0; i < 60; i++) begin
         int sel = $urandom_range(0, 9);
         int d = (sel == 0) ? 0 : (sel < 3) ? $urandom_range(20, 127) : $urandom_range(128, 400);
         int ep = ($urandom_range(0, 5) == 0) ? $urandom_range(2, d + 5) : 0;
         int op = ($urandom_range(0, 5) == 0) ? $urandom_range(2, d + 5) : 0;
         frame($urandom_range(18, 40), $urandom_range(1, 28), d, ep, op, $urandom_range(0, 9) == 0, 0);
      end
      // asynchronous reset in the middle of a frame
      idle(30);
      for (int r = 1; r <= 56; r++) begin
         nib(1, r > 16, 0, 0);
         chk("mid_busy", o_busy, 1);
      end
      #1 i_reset_n = 1'b0;
      #1;
      chk("arst_en", o_en, 0);
      chk("arst_cancel", o_cancel, 0);
      chk("arst_busy", o_busy, 0);
      chk("arst_pulse", {o_done, o_abort}, 0);
      chk("arst_len", o_len, 0);
      chk("arst_cnt", {o_good, o_runt, o_long, o_bad}, 0);
      chk("arst_queue", exp_q.size(), 0);
      cnt = '{0, 0, 0, 0};
      last_len = 0;
      idle_run = 0;
      exp_q.delete();
      @(negedge i_clk);
      i_reset_n = 1'b1;
      for (int r = 0; r < 20; r++) begin
         nib(1, 1, 0, 0);
         chk("post_rst_en", o_en, 0);
         chk("post_rst_busy", o_busy, 0);
      end
      idle_run = 0;
      frame(24, 16, 128, 0, 0, 0, 0);
      idle(5);
      chk("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
